// File: rtl/oled_pkg.sv
// rtl/oled_pkg.sv - shared screen constants, RGB565 colours and sprite direction type
package oled_pkg;

  localparam int SCREEN_W = 96;
  localparam int SCREEN_H = 64;
  localparam int PIXELS   = SCREEN_W * SCREEN_H;

  localparam logic [15:0] RGB565_BLACK = 16'h0000;
  localparam logic [15:0] RGB565_RED   = 16'hF800;
  localparam logic [15:0] RGB565_GREEN = 16'h07E0;
  localparam logic [15:0] RGB565_BLUE  = 16'h001F;
  localparam logic [15:0] RGB565_WHITE = 16'hFFFF;

  typedef enum logic [2:0] {
    DIR_IDLE  = 3'd0,
    DIR_UP    = 3'd1,
    DIR_DOWN  = 3'd2,
    DIR_LEFT  = 3'd3,
    DIR_RIGHT = 3'd4
  } dir_e;

endpackage

// File: rtl/pixel_coord.sv
// rtl/pixel_coord.sv - combinational row-major pixel_index to (col, row, valid) decode
module pixel_coord
  import oled_pkg::*;
#(
  parameter int WIDTH  = SCREEN_W,
  parameter int HEIGHT = SCREEN_H
) (
  input  logic [12:0] pixel_index_i,
  output logic [6:0]  col_o,
  output logic [5:0]  row_o,
  output logic        valid_o
);

  // row/col of out-of-range indices are meaningless; consumers must gate on valid_o
  assign col_o   = 7'(pixel_index_i % 13'(WIDTH));
  assign row_o   = 6'(pixel_index_i / 13'(WIDTH));
  assign valid_o = pixel_index_i < 13'(WIDTH * HEIGHT);

endmodule

// File: rtl/moving_square.sv
// rtl/moving_square.sv - button-steered square sprite, position updated only at frame end
// MOVING_SQUARE_WRAP_EN: toroidal wrap of position and pixel test instead of clamping
module moving_square
  import oled_pkg::*;
#(
  parameter int          WIDTH           = SCREEN_W,
  parameter int          HEIGHT          = SCREEN_H,
  parameter int          HALF            = 6,
  parameter int          STEP            = 1,
  parameter int          FRAMES_PER_STEP = 1,
  parameter logic [15:0] FG              = RGB565_RED,
  parameter logic [15:0] BG              = RGB565_BLACK
) (
  input  logic        clk25,
  input  logic        rst_n,
  input  logic [12:0] pixel_index,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_stop,
  output logic [15:0] color,
  output logic [6:0]  cx,
  output logic [5:0]  cy,
  output logic        moving
);

  localparam int              CW       = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(FRAMES_PER_STEP - 1);
  localparam logic [12:0]     LAST_PIX = 13'(WIDTH * HEIGHT - 1);

  dir_e            state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [6:0]      cx_q, cx_d;
  logic [5:0]      cy_q, cy_d;
  logic [4:0]      btn_q, hist_q;
  logic [4:0]      press;
  logic [15:0]     color_q, color_d;

  logic [6:0]        col;
  logic [5:0]        row;
  logic              valid;
  logic              frame_tick;
  logic signed [7:0] dx;
  logic signed [6:0] dy;
  logic [7:0]        adx;
  logic [6:0]        ady;
  logic              in_x, in_y;

  function automatic int step_axis(input int pos, input int delta, input int size);
    int t;
    t = pos + delta;
`ifdef MOVING_SQUARE_WRAP_EN
    if (t < 0)          t = t + size;
    else if (t >= size) t = t - size;
`else
    if (t < HALF)                 t = HALF;
    else if (t > size - 1 - HALF) t = size - 1 - HALF;
`endif
    return t;
  endfunction

  pixel_coord #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT)
  ) u_pixel_coord (
    .pixel_index_i(pixel_index),
    .col_o        (col),
    .row_o        (row),
    .valid_o      (valid)
  );

  assign frame_tick = (pixel_index == LAST_PIX);
  // bit order: stop, up, down, left, right
  assign press      = btn_q & ~hist_q;

  always_comb begin
    dx  = $signed({1'b0, col}) - $signed({1'b0, cx_q});
    dy  = $signed({1'b0, row}) - $signed({1'b0, cy_q});
    adx = dx[7] ? 8'(-dx) : 8'(dx);
    ady = dy[6] ? 7'(-dy) : 7'(dy);
`ifdef MOVING_SQUARE_WRAP_EN
    in_x = (adx <= 8'(HALF)) || ((8'(WIDTH) - adx) <= 8'(HALF));
    in_y = (ady <= 7'(HALF)) || ((7'(HEIGHT) - ady) <= 7'(HALF));
`else
    in_x = (adx <= 8'(HALF));
    in_y = (ady <= 7'(HALF));
`endif
    color_d = (valid && in_x && in_y) ? FG : BG;
  end

  // step first with the current state, then let a press override state and counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    if (frame_tick && (state_q != DIR_IDLE)) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        case (state_q)
          DIR_UP:    cy_d = 6'(step_axis(int'(cy_q), -STEP, HEIGHT));
          DIR_DOWN:  cy_d = 6'(step_axis(int'(cy_q),  STEP, HEIGHT));
          DIR_LEFT:  cx_d = 7'(step_axis(int'(cx_q), -STEP, WIDTH));
          DIR_RIGHT: cx_d = 7'(step_axis(int'(cx_q),  STEP, WIDTH));
          default:   ;
        endcase
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    if (|press) begin
      cnt_d = '0;
      if (press[4])      state_d = DIR_IDLE;
      else if (press[3]) state_d = DIR_UP;
      else if (press[2]) state_d = DIR_DOWN;
      else if (press[1]) state_d = DIR_LEFT;
      else               state_d = DIR_RIGHT;
    end
  end

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DIR_IDLE;
      cnt_q   <= '0;
      cx_q    <= 7'(WIDTH / 2);
      cy_q    <= 6'(HEIGHT / 2);
      btn_q   <= '0;
      hist_q  <= '0;
      color_q <= BG;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      btn_q   <= {btn_stop, btn_up, btn_down, btn_left, btn_right};
      hist_q  <= btn_q;
      color_q <= color_d;
    end
  end

  assign color  = color_q;
  assign cx     = cx_q;
  assign cy     = cy_q;
  assign moving = (state_q != DIR_IDLE);

endmodule

// File: tb/tb_moving_square.sv
// tb/tb_moving_square.sv - self-checking bench for moving_square at FRAMES_PER_STEP 1 and 4
module tb_moving_square;

  localparam int FG = 16'hF800;
  localparam int BG = 16'h0000;

  logic        clk25 = 1'b0;
  logic        rst_n = 1'b0;
  logic [12:0] pix   = '0;
  logic [4:0]  btn   = '0;   // stop, up, down, left, right
  logic [15:0] color  [2];
  logic [6:0]  cx     [2];
  logic [5:0]  cy     [2];
  logic        moving [2];

  always #20 clk25 = ~clk25;

  moving_square #(.FRAMES_PER_STEP(1)) u_fps1 (
    .clk25(clk25), .rst_n(rst_n), .pixel_index(pix),
    .btn_up(btn[3]), .btn_down(btn[2]), .btn_left(btn[1]), .btn_right(btn[0]), .btn_stop(btn[4]),
    .color(color[0]), .cx(cx[0]), .cy(cy[0]), .moving(moving[0])
  );

  moving_square #(.FRAMES_PER_STEP(4)) u_fps4 (
    .clk25(clk25), .rst_n(rst_n), .pixel_index(pix),
    .btn_up(btn[3]), .btn_down(btn[2]), .btn_left(btn[1]), .btn_right(btn[0]), .btn_stop(btn[4]),
    .color(color[1]), .cx(cx[1]), .cy(cy[1]), .moving(moving[1])
  );

  int passed = 0;
  int total  = 0;
  bit checking = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // reference model: screen geometry and movement rules in plain integer arithmetic
  int       m_cx[2]    = '{48, 48};
  int       m_cy[2]    = '{32, 32};
  int       m_dir[2]   = '{0, 0};   // 0 idle, 1 up, 2 down, 3 left, 4 right
  int       m_frames[2] = '{0, 0};
  int       m_color[2] = '{BG, BG};
  int       fps[2]     = '{1, 4};
  bit [4:0] seen_prev  = '0;
  bit [4:0] seen_prev2 = '0;
  bit [4:0] m_pr;

  function automatic bit in_sprite(input int p, input int x, input int y);
    int c, r, ddx, ddy;
    if (p >= 96 * 64) return 1'b0;
    c = p % 96;
    r = p / 96;
    ddx = (c > x) ? c - x : x - c;
    ddy = (r > y) ? r - y : y - r;
`ifdef MOVING_SQUARE_WRAP_EN
    if (96 - ddx < ddx) ddx = 96 - ddx;
    if (64 - ddy < ddy) ddy = 64 - ddy;
`endif
    return (ddx <= 6) && (ddy <= 6);
  endfunction

  function automatic int limit(input int v, input int size);
`ifdef MOVING_SQUARE_WRAP_EN
    return (v + size) % size;
`else
    if (v < 6) return 6;
    if (v > size - 7) return size - 7;
    return v;
`endif
  endfunction

  always @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_cx[i] = 48; m_cy[i] = 32; m_dir[i] = 0; m_frames[i] = 0; m_color[i] = BG;
      end
      seen_prev = '0;
      seen_prev2 = '0;
    end else begin
      m_pr = seen_prev & ~seen_prev2;
      seen_prev2 = seen_prev;
      seen_prev = btn;
      for (int i = 0; i < 2; i++) begin
        m_color[i] = in_sprite(int'(pix), m_cx[i], m_cy[i]) ? FG : BG;
        if (pix == 13'd6143 && m_dir[i] != 0) begin
          m_frames[i]++;
          if (m_frames[i] == fps[i]) begin
            m_frames[i] = 0;
            case (m_dir[i])
              1: m_cy[i] = limit(m_cy[i] - 1, 64);
              2: m_cy[i] = limit(m_cy[i] + 1, 64);
              3: m_cx[i] = limit(m_cx[i] - 1, 96);
              default: m_cx[i] = limit(m_cx[i] + 1, 96);
            endcase
          end
        end
        if (m_pr != 0) begin
          m_frames[i] = 0;
          m_dir[i] = m_pr[4] ? 0 : m_pr[3] ? 1 : m_pr[2] ? 2 : m_pr[1] ? 3 : 4;
        end
      end
    end
  end

  always @(negedge clk25) begin
    if (checking) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("model_color[%0d] pix=%0d", i, pix), int'(color[i]), m_color[i]);
        check($sformatf("model_cx[%0d]", i), int'(cx[i]), m_cx[i]);
        check($sformatf("model_cy[%0d]", i), int'(cy[i]), m_cy[i]);
        check($sformatf("model_moving[%0d]", i), int'(moving[i]), int'(m_dir[i] != 0));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk25);
      #3;
    end
  endtask

  task automatic ftick();
    pix = 13'd6143;
    cyc(1);
    pix = 13'd0;
    cyc(1);
  endtask

  task automatic sweep_frame(output int nfg, output int first, output int minc, output int maxc,
                             output int minr, output int maxr);
    nfg = 0; first = -1; minc = 999; maxc = -1; minr = 999; maxr = -1;
    for (int p = 0; p < 6144; p++) begin
      pix = 13'(p);
      cyc(1);
      if (color[0] == 16'(FG)) begin
        nfg++;
        if (first < 0) first = p;
        if (p % 96 < minc) minc = p % 96;
        if (p % 96 > maxc) maxc = p % 96;
        if (p / 96 < minr) minr = p / 96;
        if (p / 96 > maxr) maxr = p / 96;
      end
    end
    pix = 13'd0;
  endtask

  int nfg, first, minc, maxc, minr, maxr;
  int exp1[4] = '{49, 50, 51, 52};
  int exp4[4] = '{48, 48, 48, 49};

  initial begin
    cyc(2);
    check("rst_color", int'(color[0]), BG);
    check("rst_cx", int'(cx[0]), 48);
    check("rst_cy", int'(cy[0]), 32);
    check("rst_moving", int'(moving[0]), 0);
    rst_n = 1'b1;
    checking = 1'b1;

    sweep_frame(nfg, first, minc, maxc, minr, maxr);
    check("fg_count", nfg, 169);
    check("first_fg", first, 2538);
    check("col_min", minc, 42);
    check("col_max", maxc, 54);
    check("row_min", minr, 26);
    check("row_max", maxr, 38);

    btn = 5'b00001;
    cyc(1);
    check("press_latency_not_yet", int'(moving[0]), 0);
    btn = 5'b00000;
    cyc(1);
    check("press_latency_moving1", int'(moving[0]), 1);
    check("press_latency_moving4", int'(moving[1]), 1);
    for (int k = 0; k < 4; k++) begin
      ftick();
      check($sformatf("right_cx1_tick%0d", k + 1), int'(cx[0]), exp1[k]);
      check($sformatf("right_cx4_tick%0d", k + 1), int'(cx[1]), exp4[k]);
      check($sformatf("right_cy1_tick%0d", k + 1), int'(cy[0]), 32);
    end

    btn = 5'b10010;
    cyc(1);
    btn = 5'b00000;
    cyc(2);
    check("stop_wins", int'(moving[0]), 0);
    ftick();
    ftick();
    check("idle_cx1", int'(cx[0]), 52);
    check("idle_cx4", int'(cx[1]), 49);

    btn = 5'b01000;
    cyc(3);
`ifdef MOVING_SQUARE_WRAP_EN
    repeat (30) ftick();
    check("up_cy_wrap", int'(cy[0]), 2);
`else
    repeat (40) ftick();
    check("up_cy_clamp", int'(cy[0]), 6);
`endif
    btn = 5'b00000;
    cyc(1);
    for (int r = 0; r < 64; r++) begin
      pix = 13'(r * 96 + 48);
      cyc(1);
`ifdef MOVING_SQUARE_WRAP_EN
      check($sformatf("col48_row%0d", r), int'(color[0]), (r <= 8 || r >= 60) ? FG : BG);
`else
      check($sformatf("col48_row%0d", r), int'(color[0]), (r <= 12) ? FG : BG);
`endif
    end

    pix = 13'd6196;
    cyc(1);
    check("invalid_6196_bg", int'(color[0]), BG);
    pix = 13'd8191;
    cyc(1);
    check("invalid_8191_bg", int'(color[0]), BG);

    pix = 13'(m_cy[0] * 96 + m_cx[0]);
    cyc(1);
    check("pre_reset_fg", int'(color[0]), FG);
    rst_n = 1'b0;
    #1;
    check("async_rst_color", int'(color[0]), BG);
    check("async_rst_cx", int'(cx[0]), 48);
    check("async_rst_cy", int'(cy[0]), 32);
    check("async_rst_cx4", int'(cx[1]), 48);
    check("async_rst_moving", int'(moving[0]), 0);
    cyc(2);
    rst_n = 1'b1;
    for (int p = int'(pix) + 1; p < 6144; p++) begin
      pix = 13'(p);
      cyc(1);
    end
    sweep_frame(nfg, first, minc, maxc, minr, maxr);
    check("post_rst_fg_count", nfg, 169);
    check("post_rst_first_fg", first, 2538);

    checking = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
